siso_extrinsic_interleaver: RTL and testbench

//  Downstream stage of the max-log-MAP SISO decoder. Collects one block of a-posteriori LLRs
//  and forms scaled, saturated extrinsic values. Re-orders them through an affine interleaver
//  (or de-interleaver), then streams them out as a-priori input for the next half-iteration.

---
 rtl/siso_extrinsic_interleaver.sv | 154 +++++++++++++++
 tb/tb_siso_extrinsic_interleaver.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/siso_extrinsic_interleaver.sv
// Extrinsic scaling/saturation stage with block interleaver for the max-log-MAP SISO loop.
// Fills one block in natural order, then drains it in affine-permuted order.
module siso_extrinsic_interleaver #(
   parameter int DATA_SIZE  = 10,
   parameter int INPUT_SIZE = 5,
   parameter int BLOCK_SIZE = 21,
   parameter int PI_A       = 5,
   parameter int PI_B       = 0,
   parameter int DEINT      = 0
) (
   input  logic                         clk_p_i,
   input  logic                         reset_n_i,
   input  logic signed [DATA_SIZE-1:0]  llr_i,
   input  logic signed [INPUT_SIZE-1:0] sys_i,
   input  logic signed [INPUT_SIZE-1:0] apr_i,
   input  logic                         in_valid_i,
   output logic                         in_ready_o,
   output logic signed [INPUT_SIZE-1:0] ext_o,
   output logic                         hard_o,
   output logic                         out_valid_o,
   input  logic                         out_ready_i,
   output logic                         out_last_o,
   output logic [4:0]                   sat_cnt_o
);

   localparam int AW = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
   localparam int DW = DATA_SIZE + 2;
   localparam int SW = DATA_SIZE + 4;
   localparam logic [AW-1:0] LAST_IDX = AW'(BLOCK_SIZE - 1);
   localparam logic [AW-1:0] ADDR_RELOAD = AW'(PI_B);

   typedef enum logic {FILL, DRAIN} state_t;

   state_t              state_q, state_d;
   logic [AW-1:0]       idx_q, idx_d;
   logic [AW-1:0]       addr_q, addr_d;
   logic [4:0]          satAcc_q, satAcc_d;
   logic [4:0]          satCnt_q, satCnt_d;
   logic [INPUT_SIZE:0] mem_q [BLOCK_SIZE];

   logic                        wrEn;
   logic [AW-1:0]               wrAddr, rdAddr, addrNext;
   logic [AW:0]                 addrSum;
   logic signed [DW-1:0]        diff;
   logic signed [SW-1:0]        diffExt, tripled, scaled;
   logic                        isSat, hardVal;
   logic signed [INPUT_SIZE-1:0] extVal;

   // In range exactly when all bits above the target sign bit match it.
   always_comb begin
      diff    = $signed({{2{llr_i[DATA_SIZE-1]}}, llr_i})
              - $signed({{(DW-INPUT_SIZE){sys_i[INPUT_SIZE-1]}}, sys_i})
              - $signed({{(DW-INPUT_SIZE){apr_i[INPUT_SIZE-1]}}, apr_i});
      diffExt = $signed({{2{diff[DW-1]}}, diff});
      tripled = diffExt + (diffExt <<< 1);
      scaled  = tripled >>> 2;
      isSat   = !((&scaled[SW-1:INPUT_SIZE-1]) || !(|scaled[SW-1:INPUT_SIZE-1]));
      if (isSat) begin
         extVal = scaled[SW-1] ? $signed({1'b1, {(INPUT_SIZE-1){1'b0}}})
                               : $signed({1'b0, {(INPUT_SIZE-1){1'b1}}});
      end else begin
         extVal = scaled[INPUT_SIZE-1:0];
      end
      hardVal = ~llr_i[DATA_SIZE-1] & (|llr_i);
   end

   always_comb begin
      addrSum = {1'b0, addr_q} + (AW+1)'(PI_A);
      if (addrSum >= (AW+1)'(BLOCK_SIZE)) begin
         addrSum = addrSum - (AW+1)'(BLOCK_SIZE);
      end
      addrNext = addrSum[AW-1:0];
   end

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      addr_d      = addr_q;
      satAcc_d    = satAcc_q;
      satCnt_d    = satCnt_q;
      wrEn        = 1'b0;
      wrAddr      = (DEINT != 0) ? addr_q : idx_q;
      rdAddr      = (DEINT != 0) ? idx_q : addr_q;
      in_ready_o  = 1'b0;
      out_valid_o = 1'b0;
      out_last_o  = 1'b0;
      ext_o       = '0;
      hard_o      = 1'b0;
      case (state_q)
         FILL: begin
            in_ready_o = 1'b1;
            if (in_valid_i) begin
               wrEn     = 1'b1;
               satAcc_d = satAcc_q + 5'(isSat);
               idx_d    = idx_q + 1'b1;
               addr_d   = addrNext;
               if (idx_q == LAST_IDX) begin
                  satCnt_d = satAcc_q + 5'(isSat);
                  satAcc_d = '0;
                  idx_d    = '0;
                  addr_d   = ADDR_RELOAD;
                  state_d  = DRAIN;
               end
            end
         end
         DRAIN: begin
            out_valid_o = 1'b1;
            ext_o       = mem_q[rdAddr][INPUT_SIZE-1:0];
            hard_o      = mem_q[rdAddr][INPUT_SIZE];
            out_last_o  = (idx_q == LAST_IDX);
            if (out_ready_i) begin
               idx_d  = idx_q + 1'b1;
               addr_d = addrNext;
               if (idx_q == LAST_IDX) begin
                  idx_d   = '0;
                  addr_d  = ADDR_RELOAD;
                  state_d = FILL;
               end
            end
         end
         default: state_d = FILL;
      endcase
   end

   // Address resets to the reload offset so the first block uses the same mapping as later ones.
   always_ff @(posedge clk_p_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q  <= FILL;
         idx_q    <= '0;
         addr_q   <= ADDR_RELOAD;
         satAcc_q <= '0;
         satCnt_q <= '0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         addr_q   <= addr_d;
         satAcc_q <= satAcc_d;
         satCnt_q <= satCnt_d;
      end
   end

   always_ff @(posedge clk_p_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         for (int k = 0; k < BLOCK_SIZE; k++) begin
            mem_q[k] <= '0;
         end
      end else if (wrEn) begin
         mem_q[wrAddr] <= {hardVal, extVal};
      end
   end

   assign sat_cnt_o = satCnt_q;

endmodule

// File: tb/tb_siso_extrinsic_interleaver.sv
// Randomized self-checking bench: an interleaving and a de-interleaving instance share
// stimulus and are compared against an arithmetic/permutation reference model.
module tb_siso_extrinsic_interleaver;

   localparam int N  = 21;
   localparam int PA = 5;
   localparam int PB = 0;

   logic              clk = 1'b0;
   logic              resetN;
   logic signed [9:0] llr;
   logic signed [4:0] sys, apr;
   logic              inValid, outReady;

   logic              inReady0, outValid0, hard0, last0;
   logic signed [4:0] ext0;
   logic [4:0]        satCnt0;
   logic              inReady1, outValid1, hard1, last1;
   logic signed [4:0] ext1;
   logic [4:0]        satCnt1;

   int checks = 0;
   int errors = 0;
   int eRef [N];
   int hRef [N];
   int sRef;

   always #5 clk = ~clk;

   siso_extrinsic_interleaver #(.PI_A(PA), .PI_B(PB), .DEINT(0)) dutInt (
      .clk_p_i(clk), .reset_n_i(resetN), .llr_i(llr), .sys_i(sys), .apr_i(apr),
      .in_valid_i(inValid), .in_ready_o(inReady0), .ext_o(ext0), .hard_o(hard0),
      .out_valid_o(outValid0), .out_ready_i(outReady), .out_last_o(last0),
      .sat_cnt_o(satCnt0));

   siso_extrinsic_interleaver #(.PI_A(PA), .PI_B(PB), .DEINT(1)) dutDeint (
      .clk_p_i(clk), .reset_n_i(resetN), .llr_i(llr), .sys_i(sys), .apr_i(apr),
      .in_valid_i(inValid), .in_ready_o(inReady1), .ext_o(ext1), .hard_o(hard1),
      .out_valid_o(outValid1), .out_ready_i(outReady), .out_last_o(last1),
      .sat_cnt_o(satCnt1));

   task automatic checkOutput(input string tag, input int observed, input int expected);
      checks++;
      if (observed != expected) begin
         errors++;
         $display("[TB] FAIL %s observed=%0d expected=%0d at %0t", tag, observed, expected, $time);
      end
   endtask

   // Extrinsic = floor(3*(llr-sys-apr)/4), clipped to the 5-bit signed range.
   task automatic refExt(input int l, input int s, input int a,
                         output int e, output int h, output int sat);
      int t, q;
      t = 3 * (l - s - a);
      q = t / 4;
      if ((t % 4 != 0) && (t < 0)) q = q - 1;
      sat = 0;
      if (q > 15) begin q = 15; sat = 1; end
      if (q < -16) begin q = -16; sat = 1; end
      e = q;
      h = (l > 0) ? 1 : 0;
   endtask

   // mode 0: directed values, 1: random, 2: random with idle inputs and backpressure.
   task automatic applyStimulus(input int mode);
      int j, i, cyc, lv, sv, av, e, h, s, src0, src1;
      j = 0; cyc = 0; sRef = 0;
      while (j < N && cyc < 200) begin
         inValid  = (mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
         outReady = 1'($urandom_range(0, 1));
         if (mode == 0) begin
            case (j)
               0:       begin lv = 8;  sv = 2; av = -2; end
               1:       begin lv = -9; sv = 0; av = 0;  end
               2, 3, 4: begin lv = 40; sv = 3; av = 5;  end
               default: begin lv = int'($urandom_range(0, 18)) - 9; sv = 0; av = 0; end
            endcase
         end else begin
            lv = int'($urandom_range(0, 1023)) - 512;
            sv = int'($urandom_range(0, 31)) - 16;
            av = int'($urandom_range(0, 31)) - 16;
         end
         llr = 10'(lv); sys = 5'(sv); apr = 5'(av);
         if (inValid) begin
            refExt(lv, sv, av, e, h, s);
            eRef[j] = e; hRef[j] = h; sRef += s;
         end
         if (j == 0) begin
            checkOutput("fillReady0", 32'(inReady0), 1);
            checkOutput("fillReady1", 32'(inReady1), 1);
            checkOutput("fillNoValid", 32'(outValid0), 0);
         end
         @(posedge clk); #1;
         if (inValid) j++;
         cyc++;
      end
      inValid = 1'b0;
      checkOutput("fillDone", j, N);
      checkOutput("drainNotReady", 32'(inReady0), 0);
      checkOutput("satCnt0", 32'(satCnt0), sRef);
      checkOutput("satCnt1", 32'(satCnt1), sRef);
      if (mode == 0) checkOutput("satDirected", 32'(satCnt0), 3);

      i = 0; cyc = 0;
      while (i < N && cyc < 400) begin
         outReady = (mode == 2) ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
         inValid  = 1'($urandom_range(0, 1));
         llr = 10'($urandom);
         src0 = (PA * i + PB) % N;
         src1 = 0;
         for (int k = 0; k < N; k++) if ((PA * k + PB) % N == i) src1 = k;
         #1;
         checkOutput("outValid0", 32'(outValid0), 1);
         checkOutput("ext0", ext0, eRef[src0]);
         checkOutput("hard0", 32'(hard0), hRef[src0]);
         checkOutput("last0", 32'(last0), (i == N - 1) ? 1 : 0);
         checkOutput("ext1", ext1, eRef[src1]);
         checkOutput("hard1", 32'(hard1), hRef[src1]);
         checkOutput("last1", 32'(last1), (i == N - 1) ? 1 : 0);
         @(posedge clk); #1;
         if (outReady) i++;
         cyc++;
      end
      checkOutput("drainDone", i, N);
      outReady = 1'b0;
      inValid  = 1'b0;
      checkOutput("backToFill0", 32'(inReady0), 1);
      checkOutput("backToFill1", 32'(inReady1), 1);
      checkOutput("idleValid", 32'(outValid0), 0);
      checkOutput("satHold", 32'(satCnt0), sRef);
   endtask

   initial begin
      resetN = 1'b0; inValid = 1'b0; outReady = 1'b0;
      llr = '0; sys = '0; apr = '0;
      #12;
      checkOutput("rstReady", 32'(inReady0), 1);
      checkOutput("rstValid", 32'(outValid0), 0);
      checkOutput("rstLast", 32'(last0), 0);
      checkOutput("rstExt", ext0, 0);
      checkOutput("rstHard", 32'(hard0), 0);
      checkOutput("rstSat", 32'(satCnt0), 0);
      resetN = 1'b1;
      @(posedge clk); #1;

      applyStimulus(0);
      applyStimulus(1);
      applyStimulus(2);
      applyStimulus(2);

      // Abandon a block after 7 samples; the next block must start cleanly at j=0.
      inValid = 1'b1;
      for (int k = 0; k < 7; k++) begin
         llr = 10'($urandom); sys = 5'($urandom); apr = 5'($urandom);
         @(posedge clk); #1;
      end
      inValid = 1'b0;
      resetN = 1'b0;
      #1;
      checkOutput("midRstReady", 32'(inReady0), 1);
      checkOutput("midRstValid", 32'(outValid0), 0);
      checkOutput("midRstValid1", 32'(outValid1), 0);
      checkOutput("midRstSat", 32'(satCnt0), 0);
      @(posedge clk); #1;
      resetN = 1'b1;
      @(posedge clk); #1;
      applyStimulus(1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
